// File: rtl/mem_pkg.sv
// Shared sizes, FSM encoding and arbitration helpers for the two-port memory arbiter.
package mem_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int N_WORDS = 8;
  localparam int N_REQ   = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Round-robin pick: on contention the requester not served last wins.
  function automatic logic pick_winner(input logic [N_REQ-1:0] req, input logic last);
    if (&req) return ~last;
    return req[1];
  endfunction

  function automatic logic [N_REQ-1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot word select decoder.
module onehot_dec3 (
  input  logic [2:0] a,
  output logic [7:0] y
);

  always_comb begin
    y = 8'd1 << a;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters single-word access to an 8x16 synchronous memory.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [N_WORDS-1:0]        mem_sel,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_data,
  input  logic [DATA_W-1:0]         mem_q
);

  logic [1:0]          state;
  logic                last;
  logic                owner;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                win;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic [ADDR_W-1:0]   dec_addr;
  logic [N_WORDS-1:0]  dec_y;

  // In IDLE the decoder sees the candidate address so mem_sel is registered on the grant edge.
  always_comb begin
    win        = pick_winner(req, last);
    pick_we    = we[win];
    pick_addr  = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    pick_wdata = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    dec_addr   = (state == ST_IDLE) ? pick_addr : lat_addr;
  end

  onehot_dec3 u_dec (
    .a (dec_addr),
    .y (dec_y)
  );

  // Request payload: only meaningful while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && |req) begin
      lat_addr  <= pick_addr;
      lat_wdata <= pick_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      lat_we   <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      mem_sel  <= '0;
      mem_we   <= 1'b0;
      mem_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (|req) begin
            owner    <= win;
            lat_we   <= pick_we;
            gnt      <= idx2oh(win);
            mem_sel  <= dec_y;
            mem_we   <= pick_we;
            mem_data <= pick_wdata;
            busy     <= 1'b1;
            state    <= ST_ACCESS;
          end else begin
            gnt     <= '0;
            mem_sel <= '0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_ACCESS: begin
          mem_we   <= 1'b0;
          mem_data <= lat_wdata;
          if (lat_we) begin
            mem_sel <= '0;
            done    <= idx2oh(owner);
            state   <= ST_RESP;
          end else begin
            mem_sel <= dec_y;
            state   <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          rdata   <= mem_q;
          mem_sel <= '0;
          mem_we  <= 1'b0;
          done    <= idx2oh(owner);
          state   <= ST_RESP;
        end
        ST_RESP: begin
          done    <= '0;
          gnt     <= '0;
          busy    <= 1'b0;
          mem_sel <= '0;
          mem_we  <= 1'b0;
          last    <= owner;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 8x16 synchronous memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [15:0] rdata;
  logic        busy;
  logic [7:0]  mem_sel;
  logic        mem_we;
  logic [15:0] mem_data;
  logic [15:0] mem_q;

  logic [15:0] mem [8];
  logic        sel_bad = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .done     (done),
    .rdata    (rdata),
    .busy     (busy),
    .mem_sel  (mem_sel),
    .mem_we   (mem_we),
    .mem_data (mem_data),
    .mem_q    (mem_q)
  );

  // Memory model: write on mem_we, read data appears one cycle after mem_sel.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_sel[i]) begin
        if (mem_we) mem[i] <= mem_data;
        mem_q <= mem[i];
      end
    end
  end

  always @(negedge clk) begin
    if ($countones(mem_sel) > 1) sel_bad = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int idx, input logic w, input logic [2:0] a, input logic [15:0] d);
    req[idx]           = 1'b1;
    we[idx]            = w;
    addr[idx*3 +: 3]   = a;
    wdata[idx*16 +: 16] = d;
  endtask

  // Walks one transaction from the sampling edge; d is write data or expected read data.
  task automatic run(input int idx, input logic w, input logic [2:0] a, input logic [15:0] d,
                     input logic [1:0] drop);
    logic [1:0] oh;
    logic [7:0] sel;
    oh  = (idx == 1) ? 2'b10 : 2'b01;
    sel = 8'd1 << a;
    @(negedge clk);
    chk("acc_gnt", gnt, oh);
    chk("acc_sel", mem_sel, sel);
    chk("acc_we", mem_we, w);
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    if (w) chk("acc_mdata", mem_data, d);
    if (!w) begin
      @(negedge clk);
      chk("rdw_sel", mem_sel, sel);
      chk("rdw_we", mem_we, 0);
      chk("rdw_done", done, 0);
    end
    @(negedge clk);
    chk("resp_done", done, oh);
    chk("resp_gnt", gnt, oh);
    chk("resp_sel", mem_sel, 0);
    chk("resp_we", mem_we, 0);
    if (!w) chk("resp_rdata", rdata, d);
    req = req & ~drop;
    @(negedge clk);
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", mem_sel, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_nosel", mem_sel, 0);

    // Single write then single read of word 3
    set_req(0, 1'b1, 3'd3, 16'h0012);
    run(0, 1'b1, 3'd3, 16'h0012, 2'b01);
    set_req(1, 1'b0, 3'd3, 16'h0000);
    run(1, 1'b0, 3'd3, 16'h0012, 2'b10);

    // Preload words 1 and 6, then reset so the pointer starts fresh
    set_req(0, 1'b1, 3'd1, 16'h1111);
    run(0, 1'b1, 3'd1, 16'h1111, 2'b01);
    set_req(1, 1'b1, 3'd6, 16'h6666);
    run(1, 1'b1, 3'd6, 16'h6666, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rst2_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention after reset: requester 0 first
    set_req(0, 1'b0, 3'd1, 16'h0000);
    set_req(1, 1'b0, 3'd6, 16'h0000);
    run(0, 1'b0, 3'd1, 16'h1111, 2'b01);
    run(1, 1'b0, 3'd6, 16'h6666, 2'b10);

    // Sustained contention with writes: grants alternate
    set_req(0, 1'b1, 3'd0, 16'h00a0);
    set_req(1, 1'b1, 3'd5, 16'h00b5);
    run(0, 1'b1, 3'd0, 16'h00a0, 2'b00);
    set_req(0, 1'b1, 3'd4, 16'h00a4);
    run(1, 1'b1, 3'd5, 16'h00b5, 2'b00);
    set_req(1, 1'b1, 3'd7, 16'h00b7);
    run(0, 1'b1, 3'd4, 16'h00a4, 2'b00);
    run(1, 1'b1, 3'd7, 16'h00b7, 2'b11);
    chk("rdata_hold", rdata, 16'h6666);

    // Reset in RDWAIT
    set_req(0, 1'b0, 3'd1, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("mid_sel", mem_sel, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("mid_gnt", gnt, 0);
    chk("mid_done", done, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sel0", mem_sel, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_mdata", mem_data, 0);
    chk("mid_rdata", rdata, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_done", done, 0);
    @(negedge clk);
    chk("post_done2", done, 0);
    chk("post_we", mem_we, 0);
    set_req(0, 1'b0, 3'd1, 16'h0000);
    run(0, 1'b0, 3'd1, 16'h1111, 2'b01);

    // Requester 0 drops req during the ACCESS of a write
    set_req(0, 1'b1, 3'd2, 16'h0006);
    @(negedge clk);
    chk("drop_sel", mem_sel, 8'h04);
    chk("drop_we", mem_we, 1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("drop_done", done, 2'b01);
    @(negedge clk);
    chk("drop_idle", gnt, 0);
    set_req(1, 1'b0, 3'd2, 16'h0000);
    run(1, 1'b0, 3'd2, 16'h0006, 2'b10);

    chk("sel_onehot", sel_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and reset as decided: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester request, bit i = requester i.
- we  in  2  per-requester op, 1 = write, 0 = read.
- addr  in  6  packed word index, addr[3i+2:3i] = requester i.
- wdata  in  32  packed write data, wdata[16i+15:16i] = requester i.
- gnt  out  2  one-hot; requester i owns the memory.
- done  out  2  one-cycle completion pulse per requester.
- rdata  out  16  read result, valid while done is high.
- busy  out  1  high whenever the FSM is not IDLE.
- mem_sel  out  8  one-hot word select to the 8x16 memory (addr0..addr7).
- mem_we  out  1  memory write enable (WEn).
- mem_data  out  16  memory write data.
- mem_q  in  16  memory read data, valid one cycle after mem_sel is applied.

Function
REQ-003 SHALL use the FSM states IDLE, ACCESS, RDWAIT and RESP; every output SHALL be registered.
REQ-004 IDLE: with no req set, the FSM SHALL stay in IDLE with gnt=0, mem_sel=0 and mem_we=0.
REQ-005 IDLE with any req set: the FSM SHALL choose a winner, latch that requester's we, addr and wdata, set its gnt bit, and go to ACCESS.
REQ-006 ACCESS: mem_sel SHALL be the one-hot decode of the latched addr, and mem_data SHALL be the latched wdata.
REQ-007 ACCESS: mem_we SHALL equal the latched we; the next state SHALL be RESP for a write and RDWAIT for a read.
REQ-008 RDWAIT: mem_sel SHALL be held with mem_we=0, and mem_q SHALL be captured into rdata at the end of the cycle; the next state SHALL be RESP.
REQ-009 RESP: done SHALL pulse high for the granted requester for exactly one cycle, mem_sel and mem_we SHALL be 0, gnt SHALL stay set, and the next state SHALL be IDLE.
REQ-010 gnt SHALL clear on entry to IDLE.
REQ-011 Latency SHALL be measured from the clock edge that samples req in IDLE: done at cycle +2 for a write, +3 for a read.
REQ-012 Arbitration SHALL be round-robin using a last-served pointer.
- Both requesting: the requester not served last wins.
- Only one requesting: that requester wins regardless of the pointer.
- The pointer SHALL update only in RESP.
REQ-013 Requesters SHALL hold req, we, addr and wdata stable until done.
- If req is dropped mid-transaction, the transaction SHALL still complete and done SHALL still pulse.
REQ-014 A req still high in IDLE after its done SHALL be treated as a new request.
REQ-015 The non-granted requester's req SHALL be ignored until the FSM returns to IDLE; it SHALL never be lost or starved.
REQ-016 mem_sel SHALL never have more than one bit set.
REQ-017 rdata SHALL hold its last read value outside RESP and SHALL be unchanged by writes.

Reset
REQ-018 rst_n low SHALL act immediately and asynchronously, including mid-transaction:
- state = IDLE, gnt = 0, done = 0, rdata = 0, busy = 0.
- mem_sel = 0, mem_we = 0, mem_data = 0.
- pointer set so requester 0 wins the first contention.
REQ-019 A transaction interrupted by reset SHALL produce no done pulse; a write SHALL NOT be issued after reset deasserts.

Structure
REQ-020 Package mem_pkg SHALL hold DATA_W=16, ADDR_W=3, N_WORDS=8, N_REQ=2 and the FSM state encoding.
REQ-021 The 3-to-8 one-hot decode SHALL be the sub-module onehot_dec3; no other sub-modules.

Verification
REQ-022 Single write: req=01, we=01, addr[2:0]=3, wdata[15:0]=16'h0012 -> mem_sel=8'h08 and mem_we=1 for one cycle, then done=01 at cycle +2.
REQ-023 Single read: preload word 3=16'h0012; req=10, we=00, addr[5:3]=3 -> mem_sel=8'h08 for two cycles with mem_we=0, then done=10 with rdata=16'h0012 at cycle +3.
REQ-024 Contention after reset: both requesters request reads of words 1 and 6 -> requester 0 served first, then requester 1; both pulse done, with no mem_sel overlap.
REQ-025 Sustained contention: both requesters hold req for 4 transactions -> grants alternate 0,1,0,1.
REQ-026 Reset mid-read: assert rst_n=0 in RDWAIT -> all outputs 0 at once, no done pulse; the next request is served normally.
REQ-027 Dropped req: requester 0 drops req in ACCESS of a write of 16'h0006 to word 2 -> the write still completes and done pulses; a later read of word 2 returns 16'h0006.
